// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the sequential signed divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
  localparam int DIV_NB_DEFAULT = 8;
  localparam int DIV_W = 64;
  // Callers sign-extend into DIV_W bits and truncate the result back to their width.
  function automatic logic [DIV_W-1:0] abs_mag(input logic signed [DIV_W-1:0] v);
    return v[DIV_W-1] ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract step producing one quotient bit.
module div_step #(parameter int nb = 8) (
  input  logic [nb:0]   rem_i,
  input  logic          bit_i,
  input  logic [nb-1:0] dvs_i,
  output logic [nb:0]   rem_o,
  output logic          q_o
);
  logic [nb:0] shifted, trial;
  always_comb begin
    shifted = {rem_i[nb-1:0], bit_i};
    trial   = shifted - {1'b0, dvs_i};
    q_o     = ~trial[nb];
    rem_o   = q_o ? trial : shifted;
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: signed restoring divider, one quotient bit per clock, start/ready handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int nb = DIV_NB_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [nb-1:0] A,
  input  logic [nb-1:0] B,
  output logic [nb-1:0] Quotient,
  output logic [nb-1:0] Remainder,
  output logic          ready,
  output logic          div_by_zero,
  output logic          ovf
);
  localparam int CW = $clog2(nb + 1);
  div_state_t    state_q;
  logic [nb:0]   rem_q, rem_d;
  logic [nb-1:0] quo_q, a_q, b_q, a_mag, b_mag;
  logic [CW-1:0] cnt_q;
  logic          q_bit, neg, b_zero, is_ovf;
  assign a_mag  = nb'(abs_mag(DIV_W'(signed'(A))));
  assign b_mag  = nb'(abs_mag(DIV_W'(signed'(b_q))));
  assign neg    = a_q[nb-1] ^ b_q[nb-1];
  assign b_zero = b_q == '0;
  assign is_ovf = a_q == {1'b1, {(nb-1){1'b0}}} && b_q == '1;
  div_step #(.nb(nb)) u_step (
    .rem_i(rem_q),
    .bit_i(quo_q[nb-1]),
    .dvs_i(b_mag),
    .rem_o(rem_d),
    .q_o  (q_bit)
  );
  // quo_q starts as |A| and is shifted out MSB-first while quotient bits fill from the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else if (start) begin
      state_q     <= CALC;
      rem_q       <= '0;
      quo_q       <= a_mag;
      a_q         <= A;
      b_q         <= B;
      cnt_q       <= '0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      case (state_q)
        CALC: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[nb-2:0], q_bit};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(nb - 1)) state_q <= FIX;
        end
        FIX: begin
          Quotient    <= b_zero ? '1 : neg ? -quo_q : quo_q;
          Remainder   <= b_zero ? a_q : a_q[nb-1] ? -rem_q[nb-1:0] : rem_q[nb-1:0];
          div_by_zero <= b_zero;
          ovf         <= is_ovf;
          ready       <= 1'b1;
          state_q     <= DONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: random and directed checks of seq_divider against an integer-arithmetic model.
module tb_seq_divider;
  localparam int NB = 8;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] a_s = '0, b_s = '0;
  logic [NB-1:0] quotient, remainder;
  logic          ready, div_by_zero, ovf;
  logic [NB-1:0] prev_q = '0, prev_r = '0;
  int            errors = 0, checks = 0;
  seq_divider #(.nb(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (a_s),
    .B          (b_s),
    .Quotient   (quotient),
    .Remainder  (remainder),
    .ready      (ready),
    .div_by_zero(div_by_zero),
    .ovf        (ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                       output logic [NB-1:0] q, output logic [NB-1:0] r,
                       output logic dz, output logic ov);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    dz = ib == 0;
    ov = ia == -(1 << (NB - 1)) && ib == -1;
    if (dz) begin
      q = '1;
      r = a;
    end else begin
      q = NB'(ia / ib);
      r = NB'(ia % ib);
    end
  endtask
  task automatic run_div(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [NB-1:0] eq, er;
    logic          ed, eo;
    int            n;
    model(a, b, eq, er, ed, eo);
    start = 1'b1;
    a_s   = a;
    b_s   = b;
    @(negedge clk);
    start = 1'b0;
    check("ready_clr", 32'(ready), 32'(0));
    check("q_hold", 32'(quotient), 32'(prev_q));
    check("r_hold", 32'(remainder), 32'(prev_r));
    n = 0;
    while (!ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, NB + 1);
    check("quot", 32'(quotient), 32'(eq));
    check("rem", 32'(remainder), 32'(er));
    check("dbz", 32'(div_by_zero), 32'(ed));
    check("ovf", 32'(ovf), 32'(eo));
    prev_q = eq;
    prev_r = er;
  endtask
  initial begin
    logic [NB-1:0] ra, rb;
    #12;
    check("rst_q", 32'(quotient), 32'(0));
    check("rst_r", 32'(remainder), 32'(0));
    check("rst_rdy", 32'(ready), 32'(0));
    check("rst_flags", 32'({div_by_zero, ovf}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_div(8'd100, 8'd7);
    @(negedge clk);
    check("ready_hold", 32'(ready), 32'(1));
    check("quot_hold", 32'(quotient), 32'(8'd14));
    run_div(-8'sd100, 8'd7);
    run_div(8'd100, -8'sd7);
    run_div(-8'sd100, -8'sd7);
    run_div(8'h80, 8'hFF);
    run_div(8'h80, 8'h01);
    run_div(8'd127, 8'h80);
    run_div(8'd5, 8'd0);
    run_div(8'd6, 8'd3);
    start = 1'b1;
    a_s   = 8'd100;
    b_s   = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    run_div(8'd50, 8'd5);
    start = 1'b1;
    a_s   = 8'd100;
    b_s   = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check("arst_q", 32'(quotient), 32'(0));
    check("arst_r", 32'(remainder), 32'(0));
    check("arst_flags", 32'({ready, div_by_zero, ovf}), 32'(0));
    repeat (3) @(negedge clk);
    check("arst_noload", 32'({ready, quotient}), 32'(0));
    rst_n = 1'b1;
    start = 1'b0;
    prev_q = '0;
    prev_r = '0;
    @(negedge clk);
    check("idle_after_rst", 32'(ready), 32'(0));
    run_div(8'd9, 8'd2);
    for (int i = 0; i < 150; i++) begin
      ra = NB'($urandom);
      rb = NB'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 8'h80; rb = 8'hFF; end
        2: ra = 8'h80;
        3: rb = 8'h80;
        default: ;
      endcase
      run_div(ra, rb);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
